// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry immediate-extension
// result register. Grants are combinational; the extended result is registered.
module imm_ext_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [19:0] req0_imm,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [19:0] req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src
);

  localparam int unsigned IMM_W  = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LO_W   = 12;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ptr;
  logic               ptr_nxt;
  logic               can_accept;
  logic               grant0;
  logic               grant1;
  logic [IMM_W-1:0]   sel_imm;
  logic [1:0]         sel_mode;

  // Build the 32-bit immediate for one of the four extension modes
  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                input logic [1:0]       mode);
    logic [DATA_W-1:0] res;
    unique case (mode)
      2'b00:   res = {{(DATA_W-IMM_W){1'b0}}, imm};
      2'b01:   res = {imm, {LO_W{1'b0}}};
      2'b10:   res = {{(DATA_W-LO_W){imm[LO_W-1]}}, imm[LO_W-1:0]};
      default: res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endcase
    return res;
  endfunction

  // State and priority pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= RR_INIT;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Grant selection, next-state and pointer update; no grant while in reset
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant0     = 1'b0;
    grant1     = 1'b0;
    can_accept = !rst && ((state == EMPTY) || out_ready);
    if (can_accept) begin
      grant0 = req0_valid && (!req1_valid || (ptr == 1'b0));
      grant1 = req1_valid && (!req0_valid || (ptr == 1'b1));
    end
    if (grant0 || grant1) begin
      state_nxt = FULL;
      ptr_nxt   = grant0;
    end else if ((state == FULL) && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Operand mux; only consumed in a grant cycle
  always_comb begin
    sel_imm  = req0_imm;
    sel_mode = req0_mode;
    if (grant1) begin
      sel_imm  = req1_imm;
      sel_mode = req1_mode;
    end
  end

  // Result register: loads on grant, otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= 1'b0;
    end else if (grant0 || grant1) begin
      out_data <= ext_imm(sel_imm, sel_mode);
      out_src  <= grant1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = (state == FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter: expected results are queued at grant
// time and popped when the result register loads.
module tb_imm_ext_arbiter;

  localparam bit RR_INIT = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic        src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [19:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [19:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t        sb[$];
  bit          m_full;
  bit          m_ptr;
  logic [31:0] m_data;
  bit          m_src;

  imm_ext_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_imm   (req0_imm),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_imm   (req1_imm),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [19:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {12'h000, imm};
      2'b01:   return {imm, 12'h000};
      2'b10:   return {{20{imm[11]}}, imm[11:0]};
      default: return {{12{imm[19]}}, imm};
    endcase
  endfunction

  // One clock of stimulus: mid-cycle checks of readies/outputs, then model update
  task automatic cycle(input bit r, input bit v0, input logic [19:0] i0, input logic [1:0] m0,
                       input bit v1, input logic [19:0] i1, input logic [1:0] m1, input bit ordy);
    bit   ca, g0, g1;
    exp_t e;
    exp_t got;
    rst = r; req0_valid = v0; req0_imm = i0; req0_mode = m0;
    req1_valid = v1; req1_imm = i1; req1_mode = m1; out_ready = ordy;
    @(negedge clk);
    ca = !r && (!m_full || ordy);
    g0 = ca && v0 && (!v1 || (m_ptr == 1'b0));
    g1 = ca && v1 && (!v0 || (m_ptr == 1'b1));
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("out_valid_mid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      check("out_data_hold", out_data, m_data);
      check("out_src_hold", 32'(out_src), 32'(m_src));
    end
    e = '0;
    if (g0 || g1) begin
      e.data = g0 ? ref_ext(i0, m0) : ref_ext(i1, m1);
      e.src  = g1;
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_full = 1'b0; m_data = '0; m_src = 1'b0; m_ptr = RR_INIT;
    end else if (g0 || g1) begin
      m_full = 1'b1; m_data = e.data; m_src = g1; m_ptr = g0;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    #1;
    if (g0 || g1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        got = sb.pop_front();
        check("sb_data", out_data, got.data);
        check("sb_src", 32'(out_src), 32'(got.src));
      end
    end
    if (r) begin
      check("rst_data", out_data, 32'h0);
      check("rst_src", 32'(out_src), 32'(0));
    end
    check("out_valid_post", 32'(out_valid), 32'(m_full));
  endtask

  logic [31:0] mode_exp [4];
  logic [1:0]  mode_seq [4];
  logic [31:0] saved;

  initial begin
    mode_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
    mode_exp = '{32'h80FFF000, 32'hFFFFFFFF, 32'hFFF80FFF, 32'h00080FFF};
    m_full = 1'b0; m_ptr = RR_INIT; m_data = '0; m_src = 1'b0;
    rst = 1'b1; req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
    req1_valid = 1'b0; req1_imm = '0; req1_mode = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state with both requesters asserting
    cycle(1, 1, 20'h11111, 2'b00, 1, 20'h22222, 2'b00, 1);
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_data", out_data, 32'h0);

    // Single request, zero extend
    cycle(0, 1, 20'hABCDE, 2'b00, 0, 20'h0, 2'b00, 1);
    check("basic_data", out_data, 32'h000ABCDE);
    check("basic_src", 32'(out_src), 32'(0));
    check("basic_valid", 32'(out_valid), 32'(1));

    // All extension modes, back-to-back
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 20'h80FFF, mode_seq[i], 0, 20'h0, 2'b00, 1);
      check("mode_data", out_data, mode_exp[i]);
    end

    // Round-robin alternation from reset
    cycle(1, 0, 20'h0, 2'b00, 0, 20'h0, 2'b00, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 20'(i), 2'b00, 1, 20'(100 + i), 2'b11, 1);
      check("rr_src", 32'(out_src), 32'(i % 2));
      check("rr_valid", 32'(out_valid), 32'(1));
    end

    // Stall 3 cycles with changing operands, then release
    saved = out_data;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 20'(i * 7 + 3), 2'(i), 1, 20'(i * 5 + 9), 2'(i + 1), 0);
      check("stall_data", out_data, saved);
    end
    cycle(0, 1, 20'h12345, 2'b01, 1, 20'h54321, 2'b00, 1);
    check("release_src", 32'(out_src), 32'(0));

    // Reset while full with requester 1 pending
    cycle(1, 0, 20'h0, 2'b00, 1, 20'h7FFFF, 2'b11, 1);
    check("midrst_valid", 32'(out_valid), 32'(0));
    cycle(0, 1, 20'h00FFF, 2'b10, 1, 20'h00001, 2'b00, 1);
    check("postrst_src", 32'(out_src), 32'(0));
    check("postrst_data", out_data, 32'hFFFFFFFF);

    // Drain with no requesters: valid drops, data holds
    saved = out_data;
    cycle(0, 0, 20'h0, 2'b00, 0, 20'h0, 2'b00, 1);
    check("drain_valid", 32'(out_valid), 32'(0));
    check("drain_data", out_data, saved);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 20'($urandom), 2'($urandom),
            1'($urandom), 20'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
